mc_control: RTL and testbench
=============================

MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have one clock and one reset; `rst` is synchronous and active-high.
REQ-002 SHALL have port `clock`, input, 1 bit: single clock, all state updates on rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port `instr`, input, 16 bits: IR contents, valid from DECODE onward; opcode = instr[15:12].
REQ-005 SHALL have port `zero`, input, 1 bit: ALU zero flag, sampled in EXEC.
REQ-006 SHALL have port `pc_write`, output, 1 bit: PC load enable.
REQ-007 SHALL have port `pc_src`, output, 2 bits: PC source select; 0 = PC+2, 1 = branch target, 2 = jump target.
REQ-008 SHALL have ports `ir_write`, `mem_read`, `mem_write`, `reg_write`, `in_read`, `out_write`, each output, 1 bit: datapath strobes.
REQ-009 SHALL have port `alu_op`, output, 3 bits: ALU op; 0 = ADD, 1 = SUB, 2 = AND, 3 = OR.
REQ-010 SHALL have port `alu_src_b`, output, 2 bits: ALU B select; 0 = reg, 1 = const 2, 2 = sign-extended imm.
REQ-011 SHALL have port `state`, output, 3 bits: current FSM state encoding.
REQ-012 SHALL have port `halted`, output, 1 bit: high while in HALT.
REQ-013 SHALL have port `retired`, output, 16 bits: count of completed instructions.

Function
REQ-014 SHALL implement states FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5; codes 6 and 7 SHALL go to FETCH on the next edge with all strobes 0.
REQ-015 SHALL decode opcodes as 0 ADD, 1 SUB, 2 AND, 3 OR, 4 LW, 5 SW, 6 BEQ, 7 JMP, 8 IN, 9 OUT, F HALT; A-E are illegal.
REQ-016 SHALL make all outputs Moore functions of `state` and latched opcode, except `pc_write` in EXEC for BEQ, which is `zero`.
REQ-017 SHALL, in FETCH, assert mem_read=1, ir_write=1, pc_write=1, pc_src=0, alu_src_b=1, alu_op=ADD; next state DECODE.
REQ-018 SHALL, in DECODE, latch opcode internally and assert alu_src_b=2, alu_op=ADD (branch target precompute).
REQ-019 SHALL make DECODE transitions: HALT to HALT; illegal to FETCH as NOP, counted as retired; all others to EXEC.
REQ-020 SHALL, in EXEC for ADD/SUB/AND/OR, drive alu_op=0/1/2/3 and alu_src_b=0; next state WB.
REQ-021 SHALL, in EXEC for LW/SW, drive alu_op=ADD and alu_src_b=2; next state MEM.
REQ-022 SHALL, in EXEC for BEQ, drive alu_op=SUB, alu_src_b=0, pc_src=1 and pc_write=zero; next state FETCH.
REQ-023 SHALL, in EXEC for JMP, drive pc_write=1 and pc_src=2; next state FETCH.
REQ-024 SHALL, in EXEC, drive in_read=1 for IN (next state WB) and out_write=1 for OUT (next state FETCH).
REQ-025 SHALL, in MEM, assert mem_read=1 for LW (next state WB) and mem_write=1 for SW (next state FETCH).
REQ-026 SHALL, in WB, assert reg_write=1; next state FETCH.
REQ-027 SHALL stay in HALT with halted=1 and all strobes 0 until `rst`.
REQ-028 SHALL give these cycle counts, FETCH to next FETCH: R-type/LW-less IN/SW 4, LW 5, BEQ/JMP/OUT 3, illegal 2.
REQ-029 SHALL increment `retired` by 1 on every transition into FETCH from DECODE, EXEC, MEM or WB, and on entry to HALT.
REQ-030 SHALL wrap `retired` modulo 2^16 from 0xFFFF to 0x0000.
REQ-031 SHALL never assert mem_read and mem_write in the same cycle, and never assert more than one of reg_write, mem_write, out_write.

Reset
REQ-032 SHALL, when `rst`=1 at a rising edge, set state=FETCH, retired=0, halted=0 and clear the latched opcode, regardless of current state (incl. mid-MEM or HALT).
REQ-033 SHALL force every strobe output to 0 while `rst` is high; the first FETCH strobes appear in the first cycle after `rst` falls.

Verification
REQ-034 SHALL cover: reset 10 cycles, then instr=0x1234 (SUB) -> states 0,1,2,4,0; reg_write high only in cycle 4; alu_op=1 in EXEC; retired=1.
REQ-035 SHALL cover: instr=0x4xxx (LW) -> states 0,1,2,3,4,0; mem_read in FETCH and MEM; retired=1 after 5 cycles.
REQ-036 SHALL cover: instr=0x6xxx (BEQ) with zero=1 -> pc_write=1, pc_src=1 in EXEC; with zero=0 -> pc_write=0; both 3 cycles.
REQ-037 SHALL cover: instr=0xF000 -> HALT after 2 cycles, halted=1 held 20 cycles with no strobes; rst pulse -> FETCH, retired=0.
REQ-038 SHALL cover: instr=0xB000 (illegal) -> states 0,1,0, no strobes in DECODE; retired preloaded to 0xFFFF wraps to 0x0000.
REQ-039 SHALL cover: rst asserted during MEM of SW -> mem_write=0 that cycle, state=FETCH next edge.

Source files
------------

// File: rtl/mc_control.sv
// Multi-cycle CPU control unit: FETCH/DECODE/EXEC/MEM/WB/HALT sequencer that
// drives the datapath strobes and counts retired instructions.
module mc_control (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] instr,
    input  logic        zero,
    output logic        pc_write,
    output logic [1:0]  pc_src,
    output logic        ir_write,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        in_read,
    output logic        out_write,
    output logic [2:0]  alu_op,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  state,
    output logic        halted,
    output logic [15:0] retired
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_LW   = 4'h4;
    localparam logic [3:0] OP_SW   = 4'h5;
    localparam logic [3:0] OP_BEQ  = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_IN   = 4'h8;
    localparam logic [3:0] OP_OUT  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD   = 3'd0;
    localparam logic [2:0] ALU_SUB   = 3'd1;
    localparam logic [1:0] PC_PLUS2  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] SRCB_REG  = 2'd0;
    localparam logic [1:0] SRCB_TWO  = 2'd1;
    localparam logic [1:0] SRCB_IMM  = 2'd2;

    state_t      state_q, state_d;
    logic [3:0]  opcode_q, opcode_d;
    logic [15:0] retired_q, retired_d;
    logic        retire;
    logic [3:0]  dec_op;
    logic        unused_instr_bits;

    assign dec_op            = instr[15:12];
    assign unused_instr_bits = ^instr[11:0];

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        opcode_d  = opcode_q;
        retire    = 1'b0;
        pc_write  = 1'b0;
        pc_src    = PC_PLUS2;
        ir_write  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        in_read   = 1'b0;
        out_write = 1'b0;
        alu_op    = ALU_ADD;
        alu_src_b = SRCB_REG;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = SRCB_TWO;
                state_d   = S_DECODE;
            end
            S_DECODE: begin
                opcode_d  = dec_op;
                alu_src_b = SRCB_IMM;
                if (dec_op == OP_HALT) begin
                    state_d = S_HALT;
                end else if (dec_op > OP_OUT) begin
                    state_d = S_FETCH;       // illegal opcode retires as a NOP
                end else begin
                    state_d = S_EXEC;
                end
                retire = (state_d != S_EXEC);
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (opcode_q)
                    OP_ADD, OP_SUB, OP_AND, OP_OR: begin
                        alu_op  = opcode_q[2:0];
                        state_d = S_WB;
                    end
                    OP_LW, OP_SW: begin
                        alu_src_b = SRCB_IMM;
                        state_d   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_op   = ALU_SUB;
                        pc_src   = PC_BRANCH;
                        pc_write = zero;
                    end
                    OP_JMP: begin
                        pc_write = 1'b1;
                        pc_src   = PC_JUMP;
                    end
                    OP_IN: begin
                        in_read = 1'b1;
                        state_d = S_WB;
                    end
                    OP_OUT:  out_write = 1'b1;
                    default: ;
                endcase
                retire = (state_d == S_FETCH);
            end
            S_MEM: begin
                if (opcode_q == OP_LW) begin
                    mem_read = 1'b1;
                    state_d  = S_WB;
                end else begin
                    mem_write = (opcode_q == OP_SW);
                    state_d   = S_FETCH;
                end
                retire = (state_d == S_FETCH);
            end
            S_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
                retire    = 1'b1;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase

        retired_d = retired_q + {15'd0, retire};

        // Reset is synchronous, so the strobes must be masked combinationally meanwhile.
        if (rst) begin
            pc_write  = 1'b0;
            pc_src    = PC_PLUS2;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            in_read   = 1'b0;
            out_write = 1'b0;
            alu_op    = ALU_ADD;
            alu_src_b = SRCB_REG;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock) begin
        if (rst) begin
            state_q   <= S_FETCH;
            opcode_q  <= 4'h0;
            retired_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign halted  = (state_q == S_HALT);
    assign retired = retired_q;

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed vector table, reset/halt/wrap
// sequences and random instruction streams against a cycle-budget model.
module tb_mc_control;

    logic        clock, rst, zero;
    logic [15:0] instr;
    logic        pc_write, ir_write, mem_read, mem_write, reg_write, in_read, out_write, halted;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  alu_op, state;
    logic [15:0] retired;

    mc_control dut (
        .clock(clock), .rst(rst), .instr(instr), .zero(zero),
        .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
        .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
        .in_read(in_read), .out_write(out_write), .alu_op(alu_op),
        .alu_src_b(alu_src_b), .state(state), .halted(halted), .retired(retired)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    localparam logic [2:0] ST_F = 3'd0, ST_D = 3'd1, ST_E = 3'd2, ST_M = 3'd3, ST_W = 3'd4, ST_H = 3'd5;

    typedef struct packed {
        logic [2:0] st;
        logic       halted;
        logic       pc_write;
        logic [1:0] pc_src;
        logic       ir_write;
        logic       mem_read;
        logic       mem_write;
        logic       reg_write;
        logic       in_read;
        logic       out_write;
        logic [2:0] alu_op;
        logic [1:0] alu_src_b;
    } obs_t;

    typedef struct {
        logic [15:0] ins;
        logic        z;
        logic [23:0] seq;   // one hex digit per cycle, left to right, from FETCH
        string       name;
    } vec_t;

    vec_t        vecs[15];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [15:0] ret_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Cycles from FETCH to the next FETCH (HALT: cycles until HALT is entered).
    function automatic int n_cycles(input logic [3:0] op);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h8: return 4;
            4'h4:                               return 5;
            4'h6, 4'h7, 4'h9:                   return 3;
            default:                            return 2;
        endcase
    endfunction

    function automatic logic [2:0] exp_state(input logic [3:0] op, input int c);
        case (c)
            0:       return ST_F;
            1:       return ST_D;
            2:       return ST_E;
            3:       return (op == 4'h4 || op == 4'h5) ? ST_M : ST_W;
            default: return ST_W;
        endcase
    endfunction

    function automatic obs_t exp_obs(input logic [2:0] st, input logic [3:0] op, input logic z, input logic r);
        obs_t o;
        o        = '0;
        o.st     = st;
        o.halted = (st == ST_H);
        if (!r) begin
            case (st)
                ST_F: begin
                    o.mem_read = 1'b1; o.ir_write = 1'b1; o.pc_write = 1'b1; o.alu_src_b = 2'd1;
                end
                ST_D: o.alu_src_b = 2'd2;
                ST_E: begin
                    if (op <= 4'h3) o.alu_op = op[2:0];
                    else if (op == 4'h4 || op == 4'h5) o.alu_src_b = 2'd2;
                    else if (op == 4'h6) begin o.alu_op = 3'd1; o.pc_src = 2'd1; o.pc_write = z; end
                    else if (op == 4'h7) begin o.pc_write = 1'b1; o.pc_src = 2'd2; end
                    else if (op == 4'h8) o.in_read = 1'b1;
                    else if (op == 4'h9) o.out_write = 1'b1;
                end
                ST_M: begin
                    o.mem_read  = (op == 4'h4);
                    o.mem_write = (op == 4'h5);
                end
                ST_W: o.reg_write = 1'b1;
                default: ;
            endcase
        end
        return o;
    endfunction

    function automatic obs_t get_obs();
        obs_t o;
        o.st = state; o.halted = halted; o.pc_write = pc_write; o.pc_src = pc_src;
        o.ir_write = ir_write; o.mem_read = mem_read; o.mem_write = mem_write;
        o.reg_write = reg_write; o.in_read = in_read; o.out_write = out_write;
        o.alu_op = alu_op; o.alu_src_b = alu_src_b;
        return o;
    endfunction

    task automatic step_check(input string tag, input logic [2:0] st, input logic [3:0] op);
        check({tag, "/outputs"}, 32'(get_obs()), 32'(exp_obs(st, op, zero, rst)));
        check({tag, "/retired"}, 32'(retired), 32'(ret_m));
        check({tag, "/exclusive"},
              32'({mem_read & mem_write, (32'(reg_write) + 32'(mem_write) + 32'(out_write)) > 1}), 32'd0);
    endtask

    task automatic run_partial(input logic [15:0] ins, input bit rand_z, input logic z, input int ncyc,
                               input string tag, input logic [23:0] seq, input bit use_seq);
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clock);
            instr = (c == 1) ? ins : 16'($urandom);
            zero  = rand_z ? 1'($urandom) : z;
            #1;
            step_check(tag, exp_state(ins[15:12], c), ins[15:12]);
            if (use_seq) check({tag, "/state_seq"}, 32'(state), 32'(seq[23 - 4*c -: 4]));
        end
    endtask

    task automatic run_instr(input logic [15:0] ins, input bit rand_z, input logic z,
                             input string tag, input logic [23:0] seq, input bit use_seq);
        run_partial(ins, rand_z, z, n_cycles(ins[15:12]), tag, seq, use_seq);
        ret_m = ret_m + 16'd1;
    endtask

    task automatic pulse_rst(input logic [2:0] st, input logic [3:0] op, input string tag);
        @(negedge clock);
        rst   = 1'b1;
        instr = 16'($urandom);
        zero  = 1'($urandom);
        #1;
        step_check(tag, st, op);
        check({tag, "/mem_write"}, 32'(mem_write), 32'd0);
        @(posedge clock);
        #1;
        rst   = 1'b0;
        ret_m = 16'h0000;
    endtask

    initial begin
        vecs[0]  = '{16'h1234, 1'b0, 24'h012400, "sub"};
        vecs[1]  = '{16'h4ABC, 1'b0, 24'h012340, "lw"};
        vecs[2]  = '{16'h6123, 1'b1, 24'h012000, "beq_taken"};
        vecs[3]  = '{16'h6123, 1'b0, 24'h012000, "beq_not_taken"};
        vecs[4]  = '{16'h0111, 1'b0, 24'h012400, "add"};
        vecs[5]  = '{16'h2FFF, 1'b1, 24'h012400, "and"};
        vecs[6]  = '{16'h3000, 1'b0, 24'h012400, "or"};
        vecs[7]  = '{16'h5123, 1'b0, 24'h012300, "sw"};
        vecs[8]  = '{16'h7456, 1'b1, 24'h012000, "jmp"};
        vecs[9]  = '{16'h8000, 1'b0, 24'h012400, "in"};
        vecs[10] = '{16'h9000, 1'b1, 24'h012000, "out"};
        vecs[11] = '{16'hB000, 1'b0, 24'h010000, "illegal_b"};
        vecs[12] = '{16'hA5A5, 1'b1, 24'h010000, "illegal_a"};
        vecs[13] = '{16'hE000, 1'b0, 24'h010000, "illegal_e"};
        vecs[14] = '{16'hCFFF, 1'b0, 24'h010000, "illegal_c"};

        rst   = 1'b1;
        instr = 16'h0000;
        zero  = 1'b0;
        ret_m = 16'h0000;

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            instr = 16'($urandom);
            zero  = 1'($urandom);
            #1;
            step_check("reset", ST_F, 4'h0);
        end
        @(posedge clock);
        #1;
        rst = 1'b0;

        foreach (vecs[i]) run_instr(vecs[i].ins, 1'b0, vecs[i].z, vecs[i].name, vecs[i].seq, 1'b1);

        for (int i = 0; i < 300; i++) begin
            logic [3:0] op;
            op = 4'($urandom_range(0, 14));
            run_instr({op, 12'($urandom)}, 1'b1, 1'b0, "random", 24'h0, 1'b0);
        end

        run_instr(16'hF000, 1'b1, 1'b0, "halt_entry", 24'h010000, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            instr = 16'($urandom);
            zero  = 1'($urandom);
            #1;
            step_check("halt_hold", ST_H, 4'hF);
        end
        pulse_rst(ST_H, 4'hF, "halt_rst");
        run_instr(16'h1234, 1'b0, 1'b0, "after_halt_rst", 24'h012400, 1'b1);

        run_partial(16'h5123, 1'b1, 1'b0, 3, "sw_before_rst", 24'h012000, 1'b1);
        pulse_rst(ST_M, 4'h5, "sw_mem_rst");
        run_instr(16'h9000, 1'b0, 1'b0, "after_mem_rst", 24'h012000, 1'b1);

        @(posedge clock);
        #1;
        force dut.retired_q = 16'hFFFF;
        #1;
        release dut.retired_q;
        ret_m = 16'hFFFF;
        run_instr(16'hB000, 1'b0, 1'b0, "wrap_illegal", 24'h010000, 1'b1);
        run_instr(16'h0000, 1'b0, 1'b0, "after_wrap", 24'h012400, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
